// File: rtl/hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit
//   Hazard and scheduling unit for a 5-stage ARM pipeline (F/D/E/M/W).
//
//   It keeps its own scoreboard copy of each in-flight instruction's
//   destination register and write/load/PC-write flags. From that copy it
//   derives the Execute-stage forwarding selects, the F/D stall, and the
//   D/E flush for load-use, PC-write and taken-branch hazards. It also keeps
//   saturating stall and flush performance counters.
//
// Ports
//   clk, reset         clock and synchronous active-high reset
//   RA1D, RA2D, WA3D   Decode source and destination register numbers
//   RegWriteD          Decode instruction writes the register file
//   MemtoRegD          Decode instruction is a load
//   PCSrcD             Decode instruction writes R15
//   CondExE            condition passes for the instruction in Execute
//   BranchTakenE       branch in Execute is taken
//   ForwardAE/BE       SrcA/SrcB select: 00 regfile, 01 ResultW, 10 ALUResultM
//   StallF, StallD     hold the PC register and the F/D register
//   FlushD, FlushE     clear F/D, and clear the D/E control bits
//   PCSrcW             scoreboard PC-write bit in Writeback
//   StallCount         saturating count of cycles with StallF=1
//   FlushCount         saturating count of cycles with BranchTakenE=1
// ---------------------------------------------------------------------------
module hazard_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       RA1D,
    input  logic [3:0]       RA2D,
    input  logic [3:0]       WA3D,
    input  logic             RegWriteD,
    input  logic             MemtoRegD,
    input  logic             PCSrcD,
    input  logic             CondExE,
    input  logic             BranchTakenE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic             PCSrcW,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    // Execute-stage scoreboard entry
    logic [3:0] ra1_e_q, ra1_e_d;
    logic [3:0] ra2_e_q, ra2_e_d;
    logic [3:0] wa3_e_q, wa3_e_d;
    logic       regwr_e_q, regwr_e_d;
    logic       memtoreg_e_q, memtoreg_e_d;
    logic       pcwr_e_q, pcwr_e_d;
    // Memory-stage entry. The load flag is not kept here because nothing
    // reads it once the instruction has left Execute.
    logic [3:0] wa3_m_q, wa3_m_d;
    logic       regwr_m_q, regwr_m_d;
    logic       pcwr_m_q, pcwr_m_d;
    // Writeback-stage entry
    logic [3:0] wa3_w_q, wa3_w_d;
    logic       regwr_w_q, regwr_w_d;
    logic       pcwr_w_q, pcwr_w_d;
    // Performance counters
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic ldr_stall;
    logic pcwr_pend;

    // R15 is never forwarded: the datapath supplies PC+8 for it.
    // A match in Memory beats a match in Writeback because it is the younger write.
    function automatic logic [1:0] fwd_sel(input logic [3:0] ra,
                                           input logic [3:0] wa_m, input logic rw_m,
                                           input logic [3:0] wa_w, input logic rw_w);
        if (ra == 4'd15)               return 2'b00;
        else if (rw_m && (ra == wa_m)) return 2'b10;
        else if (rw_w && (ra == wa_w)) return 2'b01;
        else                           return 2'b00;
    endfunction

    always_comb begin
        // The load-use check is not gated by CondExE: a failed-condition
        // load still costs its bubble.
        ldr_stall = memtoreg_e_q & regwr_e_q & ((RA1D == wa3_e_q) | (RA2D == wa3_e_q));
        pcwr_pend = PCSrcD | (pcwr_e_q & CondExE) | pcwr_m_q;

        // While reset is asserted, every hazard output is held low in the same cycle.
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        StallF    = 1'b0;
        StallD    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        if (!reset) begin
            ForwardAE = fwd_sel(ra1_e_q, wa3_m_q, regwr_m_q, wa3_w_q, regwr_w_q);
            ForwardBE = fwd_sel(ra2_e_q, wa3_m_q, regwr_m_q, wa3_w_q, regwr_w_q);
            StallF    = ldr_stall | pcwr_pend;
            StallD    = ldr_stall;
            FlushD    = pcwr_pend | pcwr_w_q | BranchTakenE;
            FlushE    = ldr_stall | BranchTakenE;
        end

        // Execute loads a bubble when flushed. It is never stalled.
        ra1_e_d      = FlushE ? 4'd0 : RA1D;
        ra2_e_d      = FlushE ? 4'd0 : RA2D;
        wa3_e_d      = FlushE ? 4'd0 : WA3D;
        regwr_e_d    = FlushE ? 1'b0 : RegWriteD;
        memtoreg_e_d = FlushE ? 1'b0 : MemtoRegD;
        pcwr_e_d     = FlushE ? 1'b0 : PCSrcD;

        // A failed condition turns the instruction into a no-op from Memory onward.
        wa3_m_d   = wa3_e_q;
        regwr_m_d = regwr_e_q & CondExE;
        pcwr_m_d  = pcwr_e_q & CondExE;

        wa3_w_d   = wa3_m_q;
        regwr_w_d = regwr_m_q;
        pcwr_w_d  = pcwr_m_q;

        // The counters saturate at all-ones.
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (StallF && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
        if (!reset && BranchTakenE && (flush_cnt_q != {CNT_W{1'b1}}))
            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ra1_e_q      <= 4'd0;
            ra2_e_q      <= 4'd0;
            wa3_e_q      <= 4'd0;
            regwr_e_q    <= 1'b0;
            memtoreg_e_q <= 1'b0;
            pcwr_e_q     <= 1'b0;
            wa3_m_q      <= 4'd0;
            regwr_m_q    <= 1'b0;
            pcwr_m_q     <= 1'b0;
            wa3_w_q      <= 4'd0;
            regwr_w_q    <= 1'b0;
            pcwr_w_q     <= 1'b0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            ra1_e_q      <= ra1_e_d;
            ra2_e_q      <= ra2_e_d;
            wa3_e_q      <= wa3_e_d;
            regwr_e_q    <= regwr_e_d;
            memtoreg_e_q <= memtoreg_e_d;
            pcwr_e_q     <= pcwr_e_d;
            wa3_m_q      <= wa3_m_d;
            regwr_m_q    <= regwr_m_d;
            pcwr_m_q     <= pcwr_m_d;
            wa3_w_q      <= wa3_w_d;
            regwr_w_q    <= regwr_w_d;
            pcwr_w_q     <= pcwr_w_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign PCSrcW     = pcwr_w_q;
    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_unit
//   Directed instruction sequences with hand-computed expected control
//   outputs. A second instance with CNT_W=2 shares the same inputs so that
//   counter saturation can be observed.
// ---------------------------------------------------------------------------
module tb_hazard_unit;

    logic        clk;
    logic        reset;
    logic [3:0]  RA1D, RA2D, WA3D;
    logic        RegWriteD, MemtoRegD, PCSrcD;
    logic        CondExE, BranchTakenE;

    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, FlushD, FlushE, PCSrcW;
    logic [15:0] StallCount, FlushCount;

    logic [1:0]  s_fwd_a, s_fwd_b;
    logic        s_stall_f, s_stall_d, s_flush_d, s_flush_e, s_pcsrc_w;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int n_checks;
    int n_fail;

    hazard_unit #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
        .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .PCSrcD(PCSrcD),
        .CondExE(CondExE), .BranchTakenE(BranchTakenE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .PCSrcW(PCSrcW), .StallCount(StallCount), .FlushCount(FlushCount)
    );

    hazard_unit #(.CNT_W(2)) dut_small (
        .clk(clk), .reset(reset),
        .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
        .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .PCSrcD(PCSrcD),
        .CondExE(CondExE), .BranchTakenE(BranchTakenE),
        .ForwardAE(s_fwd_a), .ForwardBE(s_fwd_b),
        .StallF(s_stall_f), .StallD(s_stall_d), .FlushD(s_flush_d), .FlushE(s_flush_e),
        .PCSrcW(s_pcsrc_w), .StallCount(s_stall_cnt), .FlushCount(s_flush_cnt)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Present a Decode instruction and let the combinational outputs settle.
    task automatic set_d(input logic [3:0] ra1, input logic [3:0] ra2, input logic [3:0] wa3,
                         input logic rw, input logic mr, input logic pcs);
        RA1D = ra1; RA2D = ra2; WA3D = wa3;
        RegWriteD = rw; MemtoRegD = mr; PCSrcD = pcs;
        #1;
    endtask

    task automatic nop_d();
        set_d(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Clock edge, then move 1 time unit past it before driving or sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            nop_d();
            tick();
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        reset = 1'b1;
        CondExE = 1'b1;
        BranchTakenE = 1'b0;
        nop_d();
        tick();
        tick();
        reset = 1'b0;
        #1;

        // reset state
        check_eq("rst_fwd", {ForwardAE, ForwardBE}, 4'b0000);
        check_eq("rst_hazards", {StallF, StallD, FlushD, FlushE}, 4'b0000);
        check_eq("rst_pcsrcw", PCSrcW, 1'b0);
        check_eq("rst_counts", {StallCount, FlushCount}, 32'd0);

        // ADD R1,R2,R3 then SUB R2,R1,R3 back-to-back: forward from Memory
        set_d(4'd2, 4'd3, 4'd1, 1'b1, 1'b0, 1'b0); tick();
        set_d(4'd1, 4'd3, 4'd2, 1'b1, 1'b0, 1'b0); tick();
        nop_d();
        check_eq("fwd_m_a", ForwardAE, 2'b10);
        check_eq("fwd_m_b", ForwardBE, 2'b00);
        check_eq("fwd_m_nostall", {StallF, FlushD, FlushE}, 3'b000);
        drain(3);

        // one-instruction gap: forward from Writeback
        set_d(4'd2, 4'd3, 4'd1, 1'b1, 1'b0, 1'b0); tick();
        nop_d(); tick();
        set_d(4'd1, 4'd3, 4'd2, 1'b1, 1'b0, 1'b0); tick();
        nop_d();
        check_eq("fwd_w_a", ForwardAE, 2'b01);
        drain(3);

        // LDR R4 then ADD R5,R4,R4: one-cycle load-use bubble
        set_d(4'd0, 4'd0, 4'd4, 1'b1, 1'b1, 1'b0); tick();
        set_d(4'd4, 4'd4, 4'd5, 1'b1, 1'b0, 1'b0);
        check_eq("ldr_stall", {StallF, StallD, FlushE, FlushD}, 4'b1110);
        tick();
        set_d(4'd4, 4'd4, 4'd5, 1'b1, 1'b0, 1'b0);
        check_eq("ldr_released", {StallF, StallD, FlushE}, 3'b000);
        check_eq("ldr_stallcnt1", StallCount, 16'd1);
        tick();
        nop_d();
        check_eq("ldr_fwd", {ForwardAE, ForwardBE}, 4'b0101);
        drain(3);

        // ADD R1; ADDEQ R1 failing; ORR R6,R1,R7 -> forward the first ADD
        set_d(4'd2, 4'd3, 4'd1, 1'b1, 1'b0, 1'b0); tick();
        set_d(4'd2, 4'd3, 4'd1, 1'b1, 1'b0, 1'b0); tick();
        CondExE = 1'b0;
        set_d(4'd1, 4'd7, 4'd6, 1'b1, 1'b0, 1'b0); tick();
        CondExE = 1'b1;
        nop_d();
        check_eq("condfail_fwd_a", ForwardAE, 2'b01);
        check_eq("condfail_fwd_b", ForwardBE, 2'b00);
        drain(3);

        // taken branch in Execute
        BranchTakenE = 1'b1;
        nop_d();
        check_eq("br_flush", {FlushD, FlushE, StallD, StallF}, 4'b1100);
        tick();
        BranchTakenE = 1'b0;
        nop_d();
        check_eq("br_flushcnt1", FlushCount, 16'd1);
        check_eq("br_one_cycle", {FlushD, FlushE}, 2'b00);
        drain(3);

        // load-use hazard in the same cycle as a taken branch
        set_d(4'd0, 4'd0, 4'd4, 1'b1, 1'b1, 1'b0); tick();
        BranchTakenE = 1'b1;
        set_d(4'd4, 4'd4, 4'd5, 1'b1, 1'b0, 1'b0);
        check_eq("br_ldr", {StallD, FlushD, FlushE, StallF}, 4'b1111);
        tick();
        BranchTakenE = 1'b0;
        nop_d();
        check_eq("br_ldr_counts", {StallCount, FlushCount}, {16'd2, 16'd2});
        drain(3);

        // MOV PC,R0 in Decode: PC-write pending through E and M, then W
        set_d(4'd0, 4'd0, 4'd15, 1'b1, 1'b0, 1'b1);
        check_eq("pc_d", {StallF, FlushD, PCSrcW}, 3'b110);
        tick();
        set_d(4'd15, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        check_eq("pc_e", {StallF, FlushD, PCSrcW}, 3'b110);
        tick();
        nop_d();
        check_eq("pc_m", {StallF, FlushD, PCSrcW}, 3'b110);
        check_eq("pc_r15_nofwd", ForwardAE, 2'b00);
        tick();
        nop_d();
        check_eq("pc_w", {FlushD, PCSrcW}, 2'b11);
        tick();
        nop_d();
        check_eq("pc_done", {FlushD, PCSrcW}, 2'b00);
        drain(2);

        // saturation: restart, then force 5 stall cycles
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            set_d(4'd0, 4'd0, 4'd15, 1'b1, 1'b0, 1'b1);
            check_eq("sat_stallf", s_stall_f, 1'b1);
            tick();
            #1;
            check_eq("sat_small_cnt", s_stall_cnt, (i < 3) ? i : 3);
            check_eq("sat_wide_cnt", StallCount, i);
        end

        // reset in the middle of a stall
        reset = 1'b1;
        set_d(4'd0, 4'd0, 4'd15, 1'b1, 1'b0, 1'b1);
        check_eq("rst_mid_hazard", {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE}, 8'd0);
        check_eq("rst_mid_small", {s_stall_f, s_stall_d, s_flush_d, s_flush_e, s_fwd_a, s_fwd_b}, 8'd0);
        tick();
        reset = 1'b0;
        nop_d();
        check_eq("rst_mid_counts", {StallCount, FlushCount}, 32'd0);
        check_eq("rst_mid_small_counts", {s_stall_cnt, s_flush_cnt, s_pcsrc_w}, 5'd0);
        check_eq("rst_mid_clear", {StallF, FlushD, PCSrcW}, 3'b000);
        drain(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
